sdr_dat_resp: RTL and testbench

- Synthesizable SDR SDRAM device-side data responder; the memory end of the MCB data path.
- Decodes controller commands (cs/ras/cas/we) and tracks open rows per bank.
- Captures write data from the controller under DQM, and returns read data after CAS latency with the DQM read mask applied.
- Used as the on-chip/FPGA loopback target for the MCB back-end and as the bench's memory responder.

---
 rtl/sdr_dat_pkg.sv | 59 +++++
 rtl/sdr_rd_pipe.sv | 64 ++++++
 rtl/sdr_dat_resp.sv | 216 +++++++++++++++++++++
 tb/tb_sdr_dat_resp.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_dat_pkg.sv
// Shared definitions for the SDR SDRAM data responder: command encodings,
// mode-register field codes and small decode helpers.
package sdr_dat_pkg;

  // {ras_n, cas_n, we_n} with cs_n low
  typedef enum logic [2:0] {
    CMD_LMR  = 3'b000,
    CMD_AREF = 3'b001,
    CMD_PRE  = 3'b010,
    CMD_ACT  = 3'b011,
    CMD_WR   = 3'b100,
    CMD_RD   = 3'b101,
    CMD_BST  = 3'b110,
    CMD_NOP  = 3'b111
  } sdr_cmd_e;

  // Burst-length field codes (mode register bits [2:0])
  localparam logic [2:0] BL_1 = 3'b000;
  localparam logic [2:0] BL_2 = 3'b001;
  localparam logic [2:0] BL_4 = 3'b010;
  localparam logic [2:0] BL_8 = 3'b011;

  // CAS-latency field codes (mode register bits [6:4])
  localparam logic [2:0] CL_2 = 3'b010;
  localparam logic [2:0] CL_3 = 3'b011;

  function automatic sdr_cmd_e decode_cmd(input logic cs_n, input logic ras_n,
                                          input logic cas_n, input logic we_n);
    if (cs_n) return CMD_NOP;
    return sdr_cmd_e'({ras_n, cas_n, we_n});
  endfunction

  function automatic logic bl_code_ok(input logic [2:0] code);
    return (code == BL_1) || (code == BL_2) || (code == BL_4) || (code == BL_8);
  endfunction

  function automatic logic cl_code_ok(input logic [2:0] code);
    return (code == CL_2) || (code == CL_3);
  endfunction

  // Burst length expressed as a column wrap mask (BL-1)
  function automatic logic [2:0] bl_wrap_mask(input logic [2:0] code);
    case (code)
      BL_1:    return 3'd0;
      BL_2:    return 3'd1;
      BL_4:    return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  // Column of beat k: sequential wrap inside the BL-aligned block
  function automatic logic [7:0] wrap_col(input logic [7:0] base, input logic [2:0] k,
                                          input logic [2:0] mask);
    logic [7:0] m8;
    m8 = {5'b00000, mask};
    return (base & ~m8) | ((base + {5'b00000, k}) & m8);
  endfunction

endpackage

// File: rtl/sdr_rd_pipe.sv
// Read return path: CAS-latency shift line, 2-stage DQM delay line and the
// registered dq_o / dq_oe outputs.
module sdr_rd_pipe #(
  parameter int D_W = 16,
  parameter int M_W = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           cl3_i,
  input  logic           vld_i,
  input  logic [D_W-1:0] data_i,
  input  logic [M_W-1:0] dqm_i,
  output logic [D_W-1:0] dq_o,
  output logic           dq_oe_o
);

  logic [D_W-1:0] data_q [3];
  logic [2:0]     vld_q;
  logic [M_W-1:0] dqm_p1_q;
  logic [M_W-1:0] dqm_p2_q;
  logic [D_W-1:0] dq_q;
  logic           dq_oe_q;
  logic [D_W-1:0] sel_data;
  logic           sel_vld;
  logic [D_W-1:0] lane_data;

  // Tap the shift line at CL-1 stages past the issue stage
  always_comb begin
    sel_data = cl3_i ? data_q[2] : data_q[1];
    sel_vld  = cl3_i ? vld_q[2]  : vld_q[1];
    lane_data = sel_data;
    for (int j = 0; j < M_W; j++) begin
      if (dqm_p2_q[j]) lane_data[j*8 +: 8] = 8'h00;
    end
  end

  // Control: valid line, DQM delay line and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q    <= '0;
      dqm_p1_q <= '0;
      dqm_p2_q <= '0;
      dq_q     <= '0;
      dq_oe_q  <= 1'b0;
    end else begin
      vld_q    <= {vld_q[1:0], vld_i};
      dqm_p1_q <= dqm_i;
      dqm_p2_q <= dqm_p1_q;
      dq_oe_q  <= sel_vld & ~(&dqm_p2_q);
      dq_q     <= sel_vld ? lane_data : '0;
    end
  end

  // Data shift line, no reset needed
  always_ff @(posedge clk_i) begin
    data_q[0] <= data_i;
    data_q[1] <= data_q[0];
    data_q[2] <= data_q[1];
  end

  assign dq_o    = dq_q;
  assign dq_oe_o = dq_oe_q;

endmodule

// File: rtl/sdr_dat_resp.sv
// SDR SDRAM device-side data responder: command decode, bank table,
// burst sequencing, byte-masked storage and the read return pipe.
module sdr_dat_resp
  import sdr_dat_pkg::*;
#(
  parameter int SDR_D_W  = 16,
  parameter int SDR_M_W  = 2,
  parameter int SDR_A_W  = 12,
  parameter int SDR_BA_W = 2,
  parameter int MEM_AW   = 8,
  parameter int CL_DEF   = 2
) (
  input  logic                mcb_clk,
  input  logic                mcb_rst,
  input  logic                sdr_cs_n,
  input  logic                sdr_ras_n,
  input  logic                sdr_cas_n,
  input  logic                sdr_we_n,
  input  logic [SDR_BA_W-1:0] sdr_ba,
  input  logic [SDR_A_W-1:0]  sdr_addr,
  input  logic [SDR_M_W-1:0]  sdr_dqm,
  input  logic [SDR_D_W-1:0]  dq_i,
  input  logic                dq_ie,
  output logic [SDR_D_W-1:0]  dq_o,
  output logic                dq_oe,
  output logic                err_cmd,
  output logic                err_bus
);

  localparam int NB    = 1 << SDR_BA_W;
  localparam int LO_W  = MEM_AW - SDR_BA_W;
  localparam int RC_W  = SDR_A_W + 8;
  localparam int DEPTH = 1 << MEM_AW;

  sdr_cmd_e            cmd;
  logic                cmd_rdwr;
  logic                bank_open;
  logic                term;

  logic [NB-1:0]       open_q, open_d;
  logic [SDR_A_W-1:0]  row_q [NB];
  logic [2:0]          bl_mask_q, bl_mask_d;
  logic                cl3_q, cl3_d;
  logic                err_cmd_q, err_cmd_d;
  logic                err_bus_q, err_bus_d;

  logic                burst_act_q, burst_act_d;
  logic                burst_wr_q, burst_wr_d;
  logic [SDR_BA_W-1:0] burst_ba_q, burst_ba_d;
  logic [2:0]          burst_k_q, burst_k_d;
  logic [2:0]          burst_mask_q, burst_mask_d;
  logic [SDR_A_W-1:0]  burst_row_q, burst_row_d;
  logic [7:0]          burst_col_q, burst_col_d;

  logic                beat_vld;
  logic                beat_wr;
  logic [SDR_BA_W-1:0] beat_ba;
  logic [SDR_A_W-1:0]  beat_row;
  logic [7:0]          beat_col;
  logic [RC_W-1:0]     beat_rc;
  logic [MEM_AW-1:0]   beat_idx;
  logic [SDR_M_W-1:0]  wr_lane;
  logic [SDR_D_W-1:0]  rd_data;
  logic                unused_rc;

  logic [SDR_D_W-1:0]  mem [DEPTH];

  assign cmd       = decode_cmd(sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n);
  assign cmd_rdwr  = (cmd == CMD_RD) || (cmd == CMD_WR);
  assign bank_open = open_q[sdr_ba];
  // Any new column command or BST ends a burst; PRE only when it hits the burst bank
  assign term      = cmd_rdwr || (cmd == CMD_BST) ||
                     ((cmd == CMD_PRE) && (sdr_addr[10] || (sdr_ba == burst_ba_q)));

  // Next-state for bank table, mode, errors and burst sequencer
  always_comb begin
    open_d       = open_q;
    bl_mask_d    = bl_mask_q;
    cl3_d        = cl3_q;
    err_cmd_d    = err_cmd_q;
    burst_act_d  = burst_act_q;
    burst_wr_d   = burst_wr_q;
    burst_ba_d   = burst_ba_q;
    burst_k_d    = burst_k_q;
    burst_mask_d = burst_mask_q;
    burst_row_d  = burst_row_q;
    burst_col_d  = burst_col_q;
    beat_vld     = 1'b0;
    beat_wr      = 1'b0;
    beat_ba      = sdr_ba;
    beat_row     = row_q[sdr_ba];
    beat_col     = sdr_addr[7:0];

    case (cmd)
      CMD_ACT: begin
        if (bank_open) err_cmd_d = 1'b1;
        open_d[sdr_ba] = 1'b1;
      end
      CMD_PRE: begin
        if (sdr_addr[10]) open_d = '0;
        else              open_d[sdr_ba] = 1'b0;
      end
      CMD_AREF: begin
        if (|open_q) err_cmd_d = 1'b1;
      end
      CMD_LMR: begin
        if (|open_q) err_cmd_d = 1'b1;
        if (bl_code_ok(sdr_addr[2:0]) && cl_code_ok(sdr_addr[6:4])) begin
          bl_mask_d = bl_wrap_mask(sdr_addr[2:0]);
          cl3_d     = (sdr_addr[6:4] == CL_3);
        end else begin
          err_cmd_d = 1'b1;
        end
      end
      CMD_RD, CMD_WR: begin
        if (!bank_open) err_cmd_d = 1'b1;
      end
      default: ;
    endcase

    if (cmd_rdwr && bank_open) begin
      // Beat 0 goes out on the command edge; remaining beats follow
      beat_vld     = 1'b1;
      beat_wr      = (cmd == CMD_WR);
      burst_act_d  = (bl_mask_q != 3'd0);
      burst_wr_d   = (cmd == CMD_WR);
      burst_ba_d   = sdr_ba;
      burst_k_d    = 3'd1;
      burst_mask_d = bl_mask_q;
      burst_row_d  = row_q[sdr_ba];
      burst_col_d  = sdr_addr[7:0];
    end else if (burst_act_q && !term) begin
      beat_vld    = 1'b1;
      beat_wr     = burst_wr_q;
      beat_ba     = burst_ba_q;
      beat_row    = burst_row_q;
      beat_col    = wrap_col(burst_col_q, burst_k_q, burst_mask_q);
      burst_k_d   = burst_k_q + 3'd1;
      if (burst_k_q == burst_mask_q) burst_act_d = 1'b0;
    end else if (term) begin
      burst_act_d = 1'b0;
    end
  end

  // Storage index: bank on top, low bits of {row, col} below
  assign beat_rc   = {beat_row, beat_col};
  assign beat_idx  = {beat_ba, beat_rc[LO_W-1:0]};
  assign unused_rc = ^beat_rc[RC_W-1:LO_W];
  assign rd_data   = mem[beat_idx];
  assign wr_lane   = (beat_vld && beat_wr && dq_ie) ? ~sdr_dqm : '0;

  // Bus errors: undriven unmasked write beat, or both sides driving DQ
  always_comb begin
    err_bus_d = err_bus_q;
    if (beat_vld && beat_wr && !dq_ie && !(&sdr_dqm)) err_bus_d = 1'b1;
    if (dq_oe && dq_ie) err_bus_d = 1'b1;
  end

  // Control state with asynchronous reset
  always_ff @(posedge mcb_clk or posedge mcb_rst) begin
    if (mcb_rst) begin
      open_q      <= '0;
      bl_mask_q   <= 3'd0;
      cl3_q       <= (CL_DEF == 3);
      err_cmd_q   <= 1'b0;
      err_bus_q   <= 1'b0;
      burst_act_q <= 1'b0;
      burst_wr_q  <= 1'b0;
      burst_ba_q  <= '0;
      burst_k_q   <= 3'd0;
    end else begin
      open_q      <= open_d;
      bl_mask_q   <= bl_mask_d;
      cl3_q       <= cl3_d;
      err_cmd_q   <= err_cmd_d;
      err_bus_q   <= err_bus_d;
      burst_act_q <= burst_act_d;
      burst_wr_q  <= burst_wr_d;
      burst_ba_q  <= burst_ba_d;
      burst_k_q   <= burst_k_d;
    end
  end

  // Burst address/row holding registers and open-row table, no reset needed
  always_ff @(posedge mcb_clk) begin
    burst_mask_q <= burst_mask_d;
    burst_row_q  <= burst_row_d;
    burst_col_q  <= burst_col_d;
    if (cmd == CMD_ACT) row_q[sdr_ba] <= sdr_addr;
  end

  // Byte-lane write into storage
  always_ff @(posedge mcb_clk) begin
    for (int j = 0; j < SDR_M_W; j++) begin
      if (wr_lane[j]) mem[beat_idx][j*8 +: 8] <= dq_i[j*8 +: 8];
    end
  end

  sdr_rd_pipe #(
    .D_W (SDR_D_W),
    .M_W (SDR_M_W)
  ) u_rd_pipe (
    .clk_i   (mcb_clk),
    .rst_i   (mcb_rst),
    .cl3_i   (cl3_q),
    .vld_i   (beat_vld & ~beat_wr),
    .data_i  (rd_data),
    .dqm_i   (sdr_dqm),
    .dq_o    (dq_o),
    .dq_oe_o (dq_oe)
  );

  assign err_cmd = err_cmd_q;
  assign err_bus = err_bus_q;

endmodule

// File: tb/tb_sdr_dat_resp.sv
// Directed bench for sdr_dat_resp: inputs driven and outputs sampled on the
// falling edge, so every check sees the state after the preceding rising edge.
module tb_sdr_dat_resp;
  import sdr_dat_pkg::*;

  logic        mcb_clk;
  logic        mcb_rst;
  logic        sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n;
  logic [1:0]  sdr_ba;
  logic [11:0] sdr_addr;
  logic [1:0]  sdr_dqm;
  logic [15:0] dq_i;
  logic        dq_ie;
  logic [15:0] dq_o;
  logic        dq_oe;
  logic        err_cmd;
  logic        err_bus;

  int nchk;
  int nerr;

  sdr_dat_resp #(
    .SDR_D_W (16), .SDR_M_W (2), .SDR_A_W (12), .SDR_BA_W (2), .MEM_AW (8), .CL_DEF (2)
  ) dut (
    .mcb_clk   (mcb_clk),
    .mcb_rst   (mcb_rst),
    .sdr_cs_n  (sdr_cs_n),
    .sdr_ras_n (sdr_ras_n),
    .sdr_cas_n (sdr_cas_n),
    .sdr_we_n  (sdr_we_n),
    .sdr_ba    (sdr_ba),
    .sdr_addr  (sdr_addr),
    .sdr_dqm   (sdr_dqm),
    .dq_i      (dq_i),
    .dq_ie     (dq_ie),
    .dq_o      (dq_o),
    .dq_oe     (dq_oe),
    .err_cmd   (err_cmd),
    .err_bus   (err_bus)
  );

  initial begin
    mcb_clk = 1'b0;
    forever #5 mcb_clk = ~mcb_clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one command for one cycle, then advance to the next falling edge
  task automatic step(input sdr_cmd_e c, input logic [1:0] ba, input logic [11:0] a,
                      input logic [1:0] m, input logic [15:0] d, input logic ie);
    sdr_cs_n = 1'b0;
    {sdr_ras_n, sdr_cas_n, sdr_we_n} = c;
    sdr_ba   = ba;
    sdr_addr = a;
    sdr_dqm  = m;
    dq_i     = d;
    dq_ie    = ie;
    @(negedge mcb_clk);
  endtask

  task automatic nop(input logic [1:0] m, input logic [15:0] d, input logic ie);
    step(CMD_NOP, 2'd0, 12'h000, m, d, ie);
  endtask

  task automatic do_reset();
    mcb_rst = 1'b1;
    @(negedge mcb_clk);
    mcb_rst = 1'b0;
  endtask

  logic [15:0] exp_b [4];

  initial begin
    nchk = 0;
    nerr = 0;
    mcb_rst = 1'b1;
    sdr_cs_n = 1'b1; sdr_ras_n = 1'b1; sdr_cas_n = 1'b1; sdr_we_n = 1'b1;
    sdr_ba = '0; sdr_addr = '0; sdr_dqm = '0; dq_i = '0; dq_ie = 1'b0;
    @(negedge mcb_clk);
    check("rst_oe", dq_oe, 0);
    check("rst_dq", dq_o, 0);
    check("rst_err_cmd", err_cmd, 0);
    check("rst_err_bus", err_bus, 0);
    mcb_rst = 1'b0;

    // A: CL2 BL1 write/read, plus background data in cols 4..7
    step(CMD_LMR, 0, 12'h020, 2'b00, 16'h0, 0);
    step(CMD_ACT, 0, 12'd5,   2'b00, 16'h0, 0);
    step(CMD_WR,  0, 12'd3,   2'b00, 16'hA5A5, 1);
    step(CMD_WR,  0, 12'd4,   2'b00, 16'h1111, 1);
    step(CMD_WR,  0, 12'd5,   2'b00, 16'h2222, 1);
    step(CMD_WR,  0, 12'd6,   2'b00, 16'h3333, 1);
    step(CMD_WR,  0, 12'd7,   2'b00, 16'h4444, 1);
    step(CMD_RD,  0, 12'd3,   2'b00, 16'h0, 0);
    check("a_oe_e0", dq_oe, 0);
    nop(2'b00, 16'h0, 0);
    check("a_oe_e1", dq_oe, 0);
    nop(2'b00, 16'h0, 0);
    check("a_oe_e2", dq_oe, 1);
    check("a_dq_e2", dq_o, 16'hA5A5);
    nop(2'b00, 16'h0, 0);
    check("a_oe_e3", dq_oe, 0);
    check("a_err_cmd", err_cmd, 0);
    check("a_err_bus", err_bus, 0);

    // B: CL3 BL4 masked write burst with wrap, then full read burst
    step(CMD_PRE, 0, 12'h400, 2'b00, 16'h0, 0);
    step(CMD_LMR, 0, 12'h032, 2'b00, 16'h0, 0);
    step(CMD_ACT, 0, 12'd5,   2'b00, 16'h0, 0);
    step(CMD_WR,  0, 12'd6,   2'b00, 16'h0001, 1);
    nop(2'b01, 16'h0002, 1);
    nop(2'b00, 16'h0003, 1);
    nop(2'b10, 16'h0004, 1);
    nop(2'b00, 16'h0000, 0);
    step(CMD_RD,  0, 12'd4,   2'b00, 16'h0, 0);
    nop(2'b00, 16'h0, 0);
    nop(2'b00, 16'h0, 0);
    check("b_oe_e2", dq_oe, 0);
    exp_b[0] = 16'h0003; exp_b[1] = 16'h2204; exp_b[2] = 16'h0001; exp_b[3] = 16'h0044;
    for (int k = 0; k < 4; k++) begin
      nop(2'b00, 16'h0, 0);
      check($sformatf("b_oe_%0d", k), dq_oe, 1);
      check($sformatf("b_dq_%0d", k), dq_o, exp_b[k]);
    end
    nop(2'b00, 16'h0, 0);
    check("b_oe_end", dq_oe, 0);
    check("b_err_cmd", err_cmd, 0);

    // C: read DQM latency 2: full mask hides beat 0, partial mask zeroes a lane
    step(CMD_RD, 0, 12'd4, 2'b00, 16'h0, 0);
    nop(2'b11, 16'h0, 0);
    nop(2'b01, 16'h0, 0);
    nop(2'b00, 16'h0, 0);
    check("c_oe_b0", dq_oe, 0);
    check("c_dq_b0", dq_o, 16'h0000);
    nop(2'b00, 16'h0, 0);
    check("c_oe_b1", dq_oe, 1);
    check("c_dq_b1", dq_o, 16'h2200);
    nop(2'b00, 16'h0, 0);
    check("c_dq_b2", dq_o, 16'h0001);
    nop(2'b00, 16'h0, 0);
    check("c_oe_b3", dq_oe, 1);
    check("c_dq_b3", dq_o, 16'h0044);
    check("c_err_bus", err_bus, 0);

    // D: READ to a closed bank, then AREF with a bank open
    step(CMD_RD, 1, 12'd0, 2'b00, 16'h0, 0);
    check("d_rd_closed_err", err_cmd, 1);
    for (int k = 0; k < 4; k++) begin
      nop(2'b00, 16'h0, 0);
      check($sformatf("d_oe_%0d", k), dq_oe, 0);
    end
    do_reset();
    check("d_rst_err_cmd", err_cmd, 0);
    step(CMD_ACT, 0, 12'd5, 2'b00, 16'h0, 0);
    check("d_act_err", err_cmd, 0);
    step(CMD_AREF, 0, 12'd0, 2'b00, 16'h0, 0);
    check("d_aref_err", err_cmd, 1);

    // E: BL8 read interrupted by a write two cycles later
    do_reset();
    step(CMD_LMR, 0, 12'h023, 2'b00, 16'h0, 0);
    step(CMD_ACT, 1, 12'd0,   2'b00, 16'h0, 0);
    step(CMD_RD,  1, 12'd0,   2'b00, 16'h0, 0);
    nop(2'b00, 16'h0, 0);
    step(CMD_WR,  1, 12'd0,   2'b00, 16'h0100, 1);
    check("e_oe_rd0", dq_oe, 1);
    check("e_bus_pre", err_bus, 0);
    nop(2'b00, 16'h0101, 1);
    check("e_bus_overlap", err_bus, 1);
    nop(2'b00, 16'h0102, 1);
    check("e_oe_cut", dq_oe, 0);
    for (int k = 3; k < 8; k++) nop(2'b00, 16'h0100 + 16'(k), 1);
    nop(2'b00, 16'h0, 0);
    step(CMD_RD, 1, 12'd0, 2'b00, 16'h0, 0);
    nop(2'b00, 16'h0, 0);
    for (int k = 0; k < 8; k++) begin
      nop(2'b00, 16'h0, 0);
      check($sformatf("e_rb_%0d", k), dq_o, 16'h0100 + 16'(k));
    end
    check("e_err_cmd", err_cmd, 0);

    // F: reset mid read burst, then defaults CL2/BL1 without LMR
    do_reset();
    step(CMD_LMR, 0, 12'h032, 2'b00, 16'h0, 0);
    step(CMD_ACT, 0, 12'd5,   2'b00, 16'h0, 0);
    step(CMD_RD,  0, 12'd4,   2'b00, 16'h0, 0);
    nop(2'b00, 16'h0, 0);
    nop(2'b00, 16'h0, 0);
    nop(2'b00, 16'h0, 0);
    check("f_oe_before", dq_oe, 1);
    #2 mcb_rst = 1'b1;
    #1;
    check("f_oe_async", dq_oe, 0);
    check("f_dq_async", dq_o, 0);
    @(negedge mcb_clk);
    mcb_rst = 1'b0;
    step(CMD_ACT, 0, 12'd5, 2'b00, 16'h0, 0);
    step(CMD_RD,  0, 12'd4, 2'b00, 16'h0, 0);
    nop(2'b00, 16'h0, 0);
    check("f_oe_e1", dq_oe, 0);
    nop(2'b00, 16'h0, 0);
    check("f_oe_e2", dq_oe, 1);
    check("f_dq_e2", dq_o, 16'h0003);
    nop(2'b00, 16'h0, 0);
    check("f_oe_bl1", dq_oe, 0);
    check("f_err_cmd", err_cmd, 0);
    check("f_err_bus", err_bus, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
